muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the MULT/DIV/MFHI/MFLO subset of the ALU opcode space.
- Owns the HI/LO registers and runs an iterative signed shift-add multiplier and restoring divider, one bit per cycle.
- Raises a stall to the core while busy and returns HI/LO for MFHI/MFLO.
- Sits beside the main ALU and is driven by the same 4-bit ALU opcode from ALU control.

---
 rtl/muldiv_seq.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/DIV sequencer that owns HI/LO.
// Runs a signed shift-add multiplier and a restoring divider on operand
// magnitudes, one bit per cycle, and applies the sign correction at the end.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op_valid            instruction in execute is valid
//   ula_opcode[3:0]     1000 MULT, 1001 DIV, 1010 MFLO, 1011 MFHI
//   a, b                rs / rt operands
//   busy                operation in progress
//   stall               hold the current muldiv-class instruction (comb)
//   done                one-cycle pulse after HI/LO are written
//   hi, lo              HI/LO registers
//   mf_data             HI for MFHI, otherwise LO (comb)
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [3:0]       ula_opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_start;
  logic             w_iter;
  logic             w_fix;
  logic             w_is_div_op;
  logic             w_b_zero;

  logic [WIDTH-1:0] r_a;        // |a|
  logic [WIDTH-1:0] r_b;        // |b|
  logic [WIDTH-1:0] r_p;        // MULT: upper accumulator half; DIV: remainder
  logic [WIDTH-1:0] r_m;        // MULT: multiplier/low product; DIV: quotient
  logic             r_sa;
  logic             r_sb;
  logic             r_is_div;
  logic             r_dz;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rs;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_a_orig;

  assign w_is_div_op = (ula_opcode == OP_DIV);
  assign w_b_zero    = (b == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_iter      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (op_valid && (ula_opcode == OP_MULT || w_is_div_op)) begin
          w_start     = 1'b1;
          // Divide by zero skips the iterations entirely.
          w_state_nxt = (w_is_div_op && w_b_zero) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        w_iter = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift-add step: add |a| when the low multiplier bit is set, carry kept.
  assign w_sum = r_m[0] ? ({1'b0, r_p} + {1'b0, r_a}) : {1'b0, r_p};

  // Restoring step: shifted remainder needs one extra bit for the compare.
  assign w_rs      = {r_p, r_m[WIDTH-1]};
  assign w_ge      = (w_rs >= {1'b0, r_b});
  assign w_rem_nxt = WIDTH'(w_rs - {1'b0, r_b});

  // Sign correction applied in FIX
  assign w_prod     = {r_p, r_m};
  assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_q_fix    = (r_sa ^ r_sb) ? -r_m : r_m;
  assign w_r_fix    = r_sa ? -r_p : r_p;
  assign w_a_orig   = r_sa ? -r_a : r_a;

  // Datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= w_fix;
      if (w_start) begin
        r_a      <= a[WIDTH-1] ? -a : a;
        r_b      <= b[WIDTH-1] ? -b : b;
        r_sa     <= a[WIDTH-1];
        r_sb     <= b[WIDTH-1];
        r_is_div <= w_is_div_op;
        r_dz     <= w_is_div_op && w_b_zero;
        r_cnt    <= '0;
        r_p      <= '0;
        // DIV shifts the dividend out of Q; MULT shifts the multiplier out of M.
        if (w_is_div_op) r_m <= a[WIDTH-1] ? -a : a;
        else             r_m <= b[WIDTH-1] ? -b : b;
      end else if (w_iter) begin
        if (r_cnt != CW'(WIDTH - 1)) r_cnt <= r_cnt + CW'(1);
        if (r_is_div) begin
          r_p <= w_ge ? w_rem_nxt : w_rs[WIDTH-1:0];
          r_m <= {r_m[WIDTH-2:0], w_ge};
        end else begin
          r_p <= w_sum[WIDTH:1];
          r_m <= {w_sum[0], r_m[WIDTH-1:1]};
        end
      end else if (w_fix) begin
        if (!r_is_div) begin
          hi <= w_prod_fix[PW-1:WIDTH];
          lo <= w_prod_fix[WIDTH-1:0];
        end else if (r_dz) begin
          hi <= w_a_orig;
          lo <= '1;
        end else begin
          hi <= w_r_fix;
          lo <= w_q_fix;
        end
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign stall   = busy && op_valid && (ula_opcode[3:2] == 2'b10);
  assign mf_data = (ula_opcode == OP_MFHI) ? hi : lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized MULT/DIV
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFLO = 4'b1010;
  localparam logic [3:0] OP_MFHI = 4'b1011;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [3:0]  ula_opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int n_chk = 0;
  int n_err = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .ula_opcode (ula_opcode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .mf_data    (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference {hi, lo} from signed arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == OP_MULT) return 64'(sx * sy);
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (x == MIN_INT && y == 32'hFFFF_FFFF) return {32'd0, MIN_INT};
    q = sx / sy;
    r = sx % sy;
    return {32'(r), 32'(q)};
  endfunction

  // Waits for done (sampled #1 after each edge), counting busy cycles.
  task automatic wait_done(output int bcycles);
    logic ok;
    ok = 1'b0;
    bcycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) bcycles++;
      @(posedge clk); #1;
    end
    chk("done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op_valid = 1'b1; ula_opcode = op; a = x; b = y;
    @(posedge clk); #1;
    op_valid = 1'b0; ula_opcode = 4'b0000;
  endtask

  task automatic run_check(input string tag, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y, input int exp_busy);
    int bc;
    logic [63:0] e;
    e = model(op, x, y);
    start_op(op, x, y);
    wait_done(bc);
    chk({tag, "_hi"}, hi, e[63:32]);
    chk({tag, "_lo"}, lo, e[31:0]);
    if (exp_busy > 0) chk({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    @(posedge clk); #1;
    chk({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    int bc;
    logic [63:0] e;
    logic [3:0] op;
    logic [31:0] x, y;

    rst_n = 1'b0; op_valid = 1'b0; ula_opcode = 4'b0000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    run_check("mul_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 33);
    chk("mul_7_m3_hi_abs", hi, 32'hFFFF_FFFF);
    chk("mul_7_m3_lo_abs", lo, 32'hFFFF_FFEB);
    ula_opcode = OP_MFLO; #1;
    chk("mflo_idle", mf_data, 32'hFFFF_FFEB);
    ula_opcode = OP_MFHI; #1;
    chk("mfhi_idle", mf_data, 32'hFFFF_FFFF);
    chk("stall_idle", 32'(stall), 32'd0);
    ula_opcode = 4'b0000;

    run_check("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33);
    chk("div_m7_2_lo_abs", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi_abs", hi, 32'hFFFF_FFFF);
    run_check("div_min_m1", OP_DIV, MIN_INT, 32'hFFFF_FFFF, 33);
    chk("div_min_m1_lo_abs", lo, MIN_INT);
    run_check("div_5_0", OP_DIV, 32'd5, 32'd0, 1);
    chk("div_5_0_hi_abs", hi, 32'd5);
    chk("div_5_0_lo_abs", lo, 32'hFFFF_FFFF);

    // MFHI held during busy: stalls until the done cycle, then reads new HI
    e = model(OP_MULT, 32'd1234, 32'hFFFF_0001);
    @(negedge clk);
    op_valid = 1'b1; ula_opcode = OP_MULT; a = 32'd1234; b = 32'hFFFF_0001;
    @(posedge clk); #1;
    ula_opcode = OP_MFHI;
    #1;
    begin
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (done) begin
          ok = 1'b1;
          chk("mfhi_stall_done", 32'(stall), 32'd0);
          chk("mfhi_data_done", mf_data, e[63:32]);
          break;
        end
        chk("mfhi_busy", 32'(busy), 32'd1);
        chk("mfhi_stall", 32'(stall), 32'd1);
        @(posedge clk); #2;
      end
      chk("mfhi_timeout", 32'(ok), 32'd1);
    end
    op_valid = 1'b0; ula_opcode = 4'b0000;

    // Non-muldiv opcode during busy never stalls
    e = model(OP_DIV, 32'd100, 32'd7);
    start_op(OP_DIV, 32'd100, 32'd7);
    op_valid = 1'b1; ula_opcode = 4'b0010; #1;
    for (int i = 0; i < 4; i++) begin
      chk("alu_op_stall", 32'(stall), 32'd0);
      chk("alu_op_busy", 32'(busy), 32'd1);
      @(posedge clk); #2;
    end
    op_valid = 1'b0; ula_opcode = 4'b0000;
    wait_done(bc);
    chk("div_100_7_lo", lo, e[31:0]);
    chk("div_100_7_hi", hi, e[63:32]);

    // Second MULT while busy is ignored, then runs when re-presented
    start_op(OP_MULT, 32'd3, 32'd5);
    op_valid = 1'b1; ula_opcode = OP_MULT; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; #1;
    begin
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (done) begin
          ok = 1'b1;
          chk("second_ignored_lo", lo, 32'd15);
          chk("second_ignored_hi", hi, 32'd0);
          chk("second_stall_done", 32'(stall), 32'd0);
          break;
        end
        if (i < 3) chk("second_stall", 32'(stall), 32'd1);
        @(posedge clk); #2;
      end
      chk("second_timeout", 32'(ok), 32'd1);
    end
    @(posedge clk); #1;
    op_valid = 1'b0; ula_opcode = 4'b0000;
    wait_done(bc);
    chk("m1xm1_hi", hi, 32'd0);
    chk("m1xm1_lo", lo, 32'd1);
    chk("m1xm1_busy_cycles", 32'(bc), 32'd33);

    // Reset mid-CALC clears everything without a clock edge
    run_check("pre_rst", OP_MULT, 32'd9, 32'd11, 33);
    start_op(OP_MULT, 32'd123, 32'd456);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_check("post_rst", OP_MULT, 32'd123, 32'hFFFF_FE38, 33);

    // Randomized MULT/DIV against the reference model
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
      x  = $urandom();
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 9));
        2:       y = -32'($urandom_range(1, 9));
        default: y = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) x = MIN_INT;
      e = model(op, x, y);
      run_check("rand", op, x, y, (op == OP_DIV && y == 32'd0) ? 1 : 33);
      ula_opcode = OP_MFHI; #1;
      chk("rand_mfhi", mf_data, e[63:32]);
      ula_opcode = OP_MFLO; #1;
      chk("rand_mflo", mf_data, e[31:0]);
      ula_opcode = 4'b0000;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
